// File: rtl/ysyx_23060077_lsu.sv
// Load/store unit: one AXI4-Lite-style data access per memory instruction, then a valid/ready hand-off to write-back.
// Optional misalignment/response fault reporting is enabled with `define YSYX_23060077_LSU_FAULT_EN.
module ysyx_23060077_lsu #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_result,
   input  logic [DATA_WIDTH-1:0] in_src2,
   input  logic [2:0]            in_funct3,
   input  logic                  in_mem_ren,
   input  logic                  in_mem_wen,
   input  logic [4:0]            in_rd,
   input  logic                  in_reg_wen,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [4:0]            out_rd,
   output logic                  out_reg_wen,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [2:0]            arsize,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [2:0]            awsize,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [3:0]            wstrb,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready
`ifdef YSYX_23060077_LSU_FAULT_EN
   ,output logic                 out_fault
`endif
);

   typedef enum logic [2:0] {IDLE, AR, R, AW, B, WB} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] src2;
   logic [2:0]            funct3;
   logic [1:0]            off;
   logic [3:0]            strb_base;
   logic [DATA_WIDTH-1:0] rshift;
   logic [DATA_WIDTH-1:0] load_data;

   assign off    = addr[1:0];
   assign araddr = addr;
   assign awaddr = addr;
   assign arsize = {1'b0, funct3[1:0]};
   assign awsize = {1'b0, funct3[1:0]};
   assign wdata  = src2 << {off, 3'b000};
   assign wstrb  = strb_base << off;
   assign rshift = rdata >> {off, 3'b000};

   // NOTE: every combinational block assigns its outputs first so no path can infer a latch.
   always_comb begin
      strb_base = 4'b1111;
      case (funct3[1:0])
         2'b00:   strb_base = 4'b0001;
         2'b01:   strb_base = 4'b0011;
         default: strb_base = 4'b1111;
      endcase
   end

   always_comb begin
      load_data = rshift;
      case (funct3)
         3'b000:  load_data = {{(DATA_WIDTH-8){rshift[7]}}, rshift[7:0]};
         3'b001:  load_data = {{(DATA_WIDTH-16){rshift[15]}}, rshift[15:0]};
         3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, rshift[7:0]};
         3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, rshift[15:0]};
         default: load_data = rshift;
      endcase
   end

`ifdef YSYX_23060077_LSU_FAULT_EN
   logic misaligned;
   assign misaligned = (in_funct3[1:0] == 2'b01 && in_result[0]) ||
                       (in_funct3[1:0] == 2'b10 && in_result[1:0] != 2'b00);
`else
   logic resp_unused;
   assign resp_unused = ^{rresp, bresp};
`endif

   // NOTE: state and all registered outputs use non-blocking assignments so each sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         arvalid     <= 1'b0;
         rready      <= 1'b0;
         awvalid     <= 1'b0;
         wvalid      <= 1'b0;
         bready      <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_rd      <= '0;
         out_reg_wen <= 1'b0;
         addr        <= '0;
         src2        <= '0;
         funct3      <= '0;
`ifdef YSYX_23060077_LSU_FAULT_EN
         out_fault   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               in_ready <= 1'b0;
               addr     <= in_result[ADDR_WIDTH-1:0];
               src2     <= in_src2;
               funct3   <= in_funct3;
               out_rd   <= in_rd;
`ifdef YSYX_23060077_LSU_FAULT_EN
               out_fault <= 1'b0;
`endif
               if (in_mem_ren) begin
                  state       <= AR;
                  arvalid     <= 1'b1;
                  out_reg_wen <= in_reg_wen;
               end else if (in_mem_wen) begin
                  state       <= AW;
                  awvalid     <= 1'b1;
                  wvalid      <= 1'b1;
                  out_reg_wen <= 1'b0;
               end else begin
                  state       <= WB;
                  out_valid   <= 1'b1;
                  out_data    <= in_result;
                  out_reg_wen <= in_reg_wen;
               end
`ifdef YSYX_23060077_LSU_FAULT_EN
               // Misaligned memory access never reaches the bus; later assignments win.
               if ((in_mem_ren || in_mem_wen) && misaligned) begin
                  state       <= WB;
                  arvalid     <= 1'b0;
                  awvalid     <= 1'b0;
                  wvalid      <= 1'b0;
                  out_valid   <= 1'b1;
                  out_data    <= in_result;
                  out_reg_wen <= 1'b0;
                  out_fault   <= 1'b1;
               end
`endif
            end
            AR: if (arready) begin
               arvalid <= 1'b0;
               rready  <= 1'b1;
               state   <= R;
            end
            R: if (rvalid) begin
               rready    <= 1'b0;
               out_data  <= load_data;
               out_valid <= 1'b1;
               state     <= WB;
`ifdef YSYX_23060077_LSU_FAULT_EN
               if (rresp != 2'b00) begin
                  out_fault   <= 1'b1;
                  out_reg_wen <= 1'b0;
               end
`endif
            end
            AW: begin
               // Address and data channels retire independently.
               if (awready) awvalid <= 1'b0;
               if (wready)  wvalid  <= 1'b0;
               if ((awready || !awvalid) && (wready || !wvalid)) begin
                  bready <= 1'b1;
                  state  <= B;
               end
            end
            B: if (bvalid) begin
               bready    <= 1'b0;
               out_valid <= 1'b1;
               state     <= WB;
`ifdef YSYX_23060077_LSU_FAULT_EN
               if (bresp != 2'b00) out_fault <= 1'b1;
`endif
            end
            WB: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060077_lsu.sv
// Self-checking bench for ysyx_23060077_lsu: directed cases then randomized traffic against a byte-lane model.
// Build with YSYX_23060077_LSU_FAULT_EN defined to exercise the fault port.
module tb_ysyx_23060077_lsu;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [31:0] in_result, in_src2;
   logic [2:0]  in_funct3;
   logic        in_mem_ren, in_mem_wen;
   logic [4:0]  in_rd;
   logic        in_reg_wen;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic        out_reg_wen;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;
`ifdef YSYX_23060077_LSU_FAULT_EN
   logic        out_fault;
`endif

   int total = 0;
   int bad   = 0;

   logic [2:0] load_f3  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   logic [2:0] store_f3 [3] = '{3'b000, 3'b001, 3'b010};

   ysyx_23060077_lsu dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_src2(in_src2),
      .in_funct3(in_funct3), .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen),
      .in_rd(in_rd), .in_reg_wen(in_reg_wen),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rd(out_rd), .out_reg_wen(out_reg_wen),
      .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef YSYX_23060077_LSU_FAULT_EN
      , .out_fault(out_fault)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   // Collect the accessed bytes lane by lane, then sign-extend arithmetically.
   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                              input logic [2:0] f3);
      int     off = int'(a[1:0]);
      int     n   = nbytes(f3);
      longint v   = 0;
      for (int k = 0; k < n; k++)
         if (off + k < 4) v += longint'((word >> (8 * (off + k))) & 32'hFF) << (8 * k);
      if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   function automatic logic [3:0] model_wstrb(input logic [31:0] a, input logic [2:0] f3);
      logic [3:0] s   = 4'b0000;
      int         off = int'(a[1:0]);
      for (int l = 0; l < 4; l++)
         if (l >= off && l < off + nbytes(f3)) s[l] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] src, input logic [31:0] a);
      logic [31:0] d   = 32'h0;
      int          off = int'(a[1:0]);
      for (int l = 0; l < 4; l++)
         if (l >= off) d[8*l +: 8] = src[8*(l-off) +: 8];
      return d;
   endfunction

   function automatic bit model_misaligned(input logic [31:0] a, input logic [2:0] f3);
      return (nbytes(f3) == 2 && a % 2 != 0) || (nbytes(f3) == 4 && a % 4 != 0);
   endfunction

   task automatic clear_slave();
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; out_ready = 0;
   endtask

   task automatic run(input logic [31:0] res, input logic [31:0] src, input logic [2:0] f3,
                      input logic ren, input logic wen, input logic [4:0] rd, input logic rwen,
                      input logic [31:0] word, input logic [1:0] resp,
                      input int ar_d, input int r_d, input int aw_d, input int w_d,
                      input int b_d, input int wb_d, output logic [31:0] got);
      logic        is_load, is_store, mis, bus, exp_fault, exp_rwen;
      logic [31:0] exp_data, exp_wdata;
      logic [3:0]  exp_wstrb;
      int          waitc, cyc;
      int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, wb_cnt;
      int          ar_first, r_first, aw_first, ov_first, aw_drop, w_drop;
      bit          ar_ok, aw_ok, w_ok, any_bus, done, pay_ok, rdy_low;
      logic [31:0] p_data;
      logic [4:0]  p_rd;
      logic        p_wen, p_fault;

      is_load  = ren;
      is_store = wen && !ren;
      mis      = 1'b0;
`ifdef YSYX_23060077_LSU_FAULT_EN
      mis       = (ren || wen) && model_misaligned(res, f3);
`endif
      bus       = (ren || wen) && !mis;
      exp_fault = 1'b0;
`ifdef YSYX_23060077_LSU_FAULT_EN
      exp_fault = mis || (bus && resp != 2'b00);
`endif
      exp_rwen  = (is_store || exp_fault) ? 1'b0 : rwen;
      exp_data  = is_load ? model_load(word, res, f3) : res;
      exp_wdata = model_wdata(src, res);
      exp_wstrb = model_wstrb(res, f3);

      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; wb_cnt = 0;
      ar_first = -1; r_first = -1; aw_first = -1; ov_first = -1; aw_drop = -1; w_drop = -1;
      ar_ok = 1; aw_ok = 1; w_ok = 1; any_bus = 0; done = 0; pay_ok = 1; rdy_low = 1;
      p_data = 'x; p_rd = 'x; p_wen = 'x; p_fault = 'x;

      waitc = 0;
      while (!in_ready && waitc < 20) begin step(); waitc++; end
      check("in_ready_wait", in_ready, 1);
      in_valid = 1; in_result = res; in_src2 = src; in_funct3 = f3;
      in_mem_ren = ren; in_mem_wen = wen; in_rd = rd; in_reg_wen = rwen;
      step();
      in_valid = 0; in_result = $urandom; in_src2 = $urandom; in_funct3 = 3'($urandom);
      in_rd = 5'($urandom); in_reg_wen = 1'($urandom);
      check("accepted", in_ready, 0);

      for (cyc = 1; cyc <= 100 && !done; cyc++) begin
         if (arvalid || rready || awvalid || wvalid || bready) any_bus = 1;
         if (arvalid) begin
            if (ar_first < 0) ar_first = cyc;
            if (araddr !== res || arsize !== {1'b0, f3[1:0]}) ar_ok = 0;
         end
         if (rready && r_first < 0) r_first = cyc;
         if (awvalid) begin
            if (aw_first < 0) aw_first = cyc;
            if (awaddr !== res || awsize !== {1'b0, f3[1:0]}) aw_ok = 0;
         end
         if (wvalid && (wdata !== exp_wdata || wstrb !== exp_wstrb)) w_ok = 0;
         if (aw_first >= 0 && !awvalid && aw_drop < 0) aw_drop = cyc;
         if (aw_first >= 0 && !wvalid && w_drop < 0) w_drop = cyc;
         if (out_valid) begin
            if (ov_first < 0) begin
               ov_first = cyc; p_data = out_data; p_rd = out_rd; p_wen = out_reg_wen;
`ifdef YSYX_23060077_LSU_FAULT_EN
               p_fault = out_fault;
`endif
            end else if (out_data !== p_data || out_rd !== p_rd || out_reg_wen !== p_wen) begin
               pay_ok = 0;
            end
            if (in_ready !== 1'b0) rdy_low = 0;
         end
         arready = arvalid && ar_cnt >= ar_d;   if (arvalid) ar_cnt++;
         rvalid  = rready && r_cnt >= r_d;      if (rready)  r_cnt++;
         rdata   = rvalid ? word : $urandom;
         rresp   = resp;
         awready = awvalid && aw_cnt >= aw_d;   if (awvalid) aw_cnt++;
         wready  = wvalid && w_cnt >= w_d;      if (wvalid)  w_cnt++;
         bvalid  = bready && b_cnt >= b_d;      if (bready)  b_cnt++;
         bresp   = resp;
         out_ready = out_valid && wb_cnt >= wb_d; if (out_valid) wb_cnt++;
         if (out_valid && out_ready) done = 1;
         step();
      end
      clear_slave();

      check("wb_handshake_done", done, 1);
      check("in_ready_after_wb", in_ready, 1);
      check("out_valid_dropped", out_valid, 0);
      check("out_rd", p_rd, rd);
      check("out_reg_wen", p_wen, exp_rwen);
      if (!exp_fault && !is_store) check("out_data", p_data, exp_data);
      check("payload_stable", pay_ok, 1);
      check("in_ready_low_in_wb", rdy_low, 1);
`ifdef YSYX_23060077_LSU_FAULT_EN
      check("out_fault", p_fault, exp_fault);
`endif
      if (!bus) begin
         check("no_bus_activity", any_bus, 0);
         check("bypass_latency", ov_first, 1);
      end else if (is_load) begin
         check("ar_first", ar_first, 1);
         check("ar_addr_size_stable", ar_ok, 1);
         if (ar_d == 0 && r_d == 0) begin
            check("rready_latency", r_first, 2);
            check("load_latency", ov_first, 3);
         end
      end else begin
         check("aw_first", aw_first, 1);
         check("aw_addr_size_stable", aw_ok, 1);
         check("w_data_strb_stable", w_ok, 1);
         if (aw_d == 0 && w_d == 0 && b_d == 0) check("store_latency", ov_first, 3);
         if (aw_d < w_d) check("awvalid_drops_first", aw_drop < w_drop, 1);
      end
      got = p_data;
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      logic [2:0]  f3;
      logic [1:0]  resp;
      int          kind, waitc;

      reset = 1; in_valid = 0; in_result = 0; in_src2 = 0; in_funct3 = 0;
      in_mem_ren = 0; in_mem_wen = 0; in_rd = 0; in_reg_wen = 0;
      clear_slave();
      step(); step();
      check("rst_in_ready", in_ready, 1);
      check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, out_valid}, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_rd_wen", {out_rd, out_reg_wen}, 0);
      reset = 0;
      step();
      check("idle_in_ready", in_ready, 1);

      run(32'h1234_5678, 32'h0, 3'b000, 0, 0, 5'd5, 1, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0, got);
      check("bypass_value", got, 32'h1234_5678);
      run(32'h8000_0003, 32'h0, 3'b000, 1, 0, 5'd6, 1, 32'h8011_2233, 2'b00, 0, 0, 0, 0, 0, 0, got);
      check("lb_value", got, 32'hFFFF_FF80);
      run(32'h8000_0002, 32'h0, 3'b101, 1, 0, 5'd7, 1, 32'hBEEF_0000, 2'b00, 3, 0, 0, 0, 0, 0, got);
      check("lhu_value", got, 32'h0000_BEEF);
      run(32'h8000_0001, 32'h0000_00AB, 3'b000, 0, 1, 5'd8, 1, 32'h0, 2'b00, 0, 0, 0, 1, 0, 0, got);
      run(32'hCAFE_0001, 32'h0, 3'b000, 0, 0, 5'd9, 1, 32'h0, 2'b00, 0, 0, 0, 0, 0, 4, got);
      run(32'h0000_0042, 32'h0, 3'b000, 0, 0, 5'd10, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0, got);

      // Abandon a load in R with its response pending.
      waitc = 0;
      while (!in_ready && waitc < 20) begin step(); waitc++; end
      in_valid = 1; in_result = 32'h8000_0010; in_funct3 = 3'b010; in_mem_ren = 1; in_mem_wen = 0;
      in_rd = 5'd11; in_reg_wen = 1;
      step();
      in_valid = 0; in_mem_ren = 0;
      waitc = 0;
      while (!rready && waitc < 10) begin arready = arvalid; step(); waitc++; end
      arready = 0;
      check("reached_r", rready, 1);
      rvalid = 1; rdata = 32'h5555_AAAA; reset = 1;
      step();
      check("abort_rready", rready, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_valids", {arvalid, awvalid, wvalid, bready, out_valid}, 0);
      reset = 0;
      step();
      rvalid = 0;
      check("abort_no_response", out_valid, 0);
      check("abort_idle", in_ready, 1);

`ifdef YSYX_23060077_LSU_FAULT_EN
      run(32'h8000_0002, 32'h0, 3'b010, 1, 0, 5'd12, 1, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0, got);
      run(32'h8000_0001, 32'h1111_2222, 3'b001, 0, 1, 5'd13, 1, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0, got);
      run(32'h8000_0004, 32'h0, 3'b010, 1, 0, 5'd14, 1, 32'h1234_0000, 2'b10, 0, 0, 0, 0, 0, 0, got);
`endif

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         a    = 32'h8000_0000 | $urandom_range(0, 255);
         resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if (kind == 0) begin
            f3 = load_f3[$urandom_range(0, 4)];
            run(a, $urandom, f3, 1, 1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom), $urandom,
                resp, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, $urandom_range(0, 3), got);
         end else if (kind == 1) begin
            f3 = store_f3[$urandom_range(0, 2)];
            run(a, $urandom, f3, 0, 1, 5'($urandom), 1'($urandom), 32'h0, resp, 0, 0,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), got);
         end else begin
            run($urandom, $urandom, 3'($urandom), 0, 0, 5'($urandom), 1'($urandom), 32'h0, resp,
                0, 0, 0, 0, 0, $urandom_range(0, 3), got);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
